// File: rtl/finder_row_grouper_if.sv
// rtl/finder_row_grouper_if.sv - encoding-vector input and group-result bundle for finder_row_grouper
interface finder_row_grouper_if #(
    parameter int HEIGHT     = 480,
    parameter int MAX_GROUPS = 3
);
    localparam int CW = $clog2(MAX_GROUPS + 1);

    logic [HEIGHT-1:0]       finder_encodings;
    logic                    encodings_valid;
    logic                    busy;
    logic [9*MAX_GROUPS-1:0] group_start;
    logic [9*MAX_GROUPS-1:0] group_end;
    logic [CW-1:0]           group_count;
    logic                    overflow;
    logic                    done;

    modport master (
        output finder_encodings, encodings_valid,
        input  busy, group_start, group_end, group_count, overflow, done
    );

    modport slave (
        input  finder_encodings, encodings_valid,
        output busy, group_start, group_end, group_count, overflow, done
    );
endinterface

// File: rtl/finder_row_grouper.sv
// rtl/finder_row_grouper.sv - merges flagged finder rows into vertical groups, one row per cycle
module finder_row_grouper #(
    parameter int HEIGHT     = 480,
    parameter int MIN_RUN    = 3,
    parameter int MAX_GAP    = 1,
    parameter int MAX_GROUPS = 3
) (
    input  logic             clk_in,
    input  logic             rst_in,
    finder_row_grouper_if.slave bus
);
    localparam int CW = $clog2(MAX_GROUPS + 1);
    localparam int GW = $clog2(MAX_GAP + 2);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                  state;
    logic [HEIGHT-1:0]       shadow;
    logic [8:0]              idx;
    logic [8:0]              run_start;
    logic [8:0]              last_one;
    logic                    in_run;
    logic [GW-1:0]           gap;
    logic                    busy_r;
    logic                    done_r;
    logic                    overflow_r;
    logic [CW-1:0]           count_r;
    logic [9*MAX_GROUPS-1:0] start_r;
    logic [9*MAX_GROUPS-1:0] end_r;

    logic                    bit_v;
    logic                    in_run_n;
    logic [8:0]              run_start_n;
    logic [8:0]              last_one_n;
    logic [GW-1:0]           gap_n;
    logic                    close;
    logic [8:0]              span;
    logic                    last_row;

    assign bit_v    = shadow[idx];
    assign last_row = (idx == 9'(HEIGHT - 1));

    // Next run state for the current row; close covers both gap overrun and end of vector
    always_comb begin
        in_run_n    = in_run;
        run_start_n = run_start;
        last_one_n  = last_one;
        gap_n       = gap;
        close       = 1'b0;
        if (bit_v) begin
            if (!in_run) begin
                in_run_n    = 1'b1;
                run_start_n = idx;
            end
            last_one_n = idx;
            gap_n      = '0;
        end else if (in_run) begin
            if (gap >= GW'(MAX_GAP)) close = 1'b1;
            else                     gap_n = gap + GW'(1);
        end
        if (last_row && in_run_n) close = 1'b1;
        span = last_one_n - run_start_n + 9'd1;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= IDLE;
            shadow     <= '0;
            idx        <= '0;
            run_start  <= '0;
            last_one   <= '0;
            in_run     <= 1'b0;
            gap        <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
            count_r    <= '0;
            start_r    <= '0;
            end_r      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.encodings_valid) begin
                        shadow     <= bus.finder_encodings;
                        count_r    <= '0;
                        overflow_r <= 1'b0;
                        start_r    <= '0;
                        end_r      <= '0;
                        idx        <= '0;
                        in_run     <= 1'b0;
                        gap        <= '0;
                        busy_r     <= 1'b1;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    run_start <= run_start_n;
                    last_one  <= last_one_n;
                    if (close) begin
                        in_run <= 1'b0;
                        gap    <= '0;
                        if (span >= 9'(MIN_RUN)) begin
                            if (count_r < CW'(MAX_GROUPS)) begin
                                for (int k = 0; k < MAX_GROUPS; k++) begin
                                    if (CW'(k) == count_r) begin
                                        start_r[9*k +: 9] <= run_start_n;
                                        end_r[9*k +: 9]   <= last_one_n;
                                    end
                                end
                                count_r <= count_r + CW'(1);
                            end else begin
                                overflow_r <= 1'b1;
                            end
                        end
                    end else begin
                        in_run <= in_run_n;
                        gap    <= gap_n;
                    end
                    if (last_row) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 9'd1;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.overflow    = overflow_r;
    assign bus.group_count = count_r;
    assign bus.group_start = start_r;
    assign bus.group_end   = end_r;
endmodule
